// File: rtl/rr_n_pkg.sv
// Shared constants for the rr_n round-robin AXI-Stream arbiter: FSM encoding and counter widths.
package rr_n_pkg;

  localparam logic [0:0] StArb  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  localparam int unsigned CntWidth   = 8;
  localparam int unsigned StatsWidth = 16;

endpackage

// File: rtl/rr_n_pick.sv
// Combinational rotating-priority encoder: first valid index scanning from ptr+1 upward with
// wrap-around, so ptr itself has the lowest priority.
module rr_n_pick #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned IdW      = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] valid,
  input  logic [IdW-1:0]      ptr,
  output logic [IdW-1:0]      grant,
  output logic                any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    // Walk from the farthest offset down so the nearest valid offset wins.
    for (int k = N_INPUTS; k >= 1; k--) begin
      idx = (32'(ptr) + 32'(k)) % N_INPUTS;
      if (valid[idx]) begin
        grant = IdW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_n.sv
// N-input round-robin AXI-Stream arbiter with packet- or flit-granular turns of QUANTUM units.
// Optional per-input TLAST counters on o_pkt_cnt when RR_N_STATS_EN is defined.
module rr_n
  import rr_n_pkg::*;
#(
  parameter int unsigned N_INPUTS   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TLAST_ARB  = 1,
  parameter int unsigned QUANTUM    = 1,
  localparam int unsigned IdW       = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_TDATA,
  input  logic [N_INPUTS-1:0]            s_TVALID,
  output logic [N_INPUTS-1:0]            s_TREADY,
  input  logic [N_INPUTS-1:0]            s_TLAST,
  output logic [DATA_WIDTH-1:0]          o_TDATA,
  output logic                           o_TVALID,
  input  logic                           o_TREADY,
  output logic                           o_TLAST,
  output logic [IdW-1:0]                 o_TID
`ifdef RR_N_STATS_EN
  ,
  output logic [N_INPUTS*StatsWidth-1:0] o_pkt_cnt
`endif
);

  logic [0:0]            state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        lock_q, lock_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  mid_q, mid_d;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q;
  logic [IdW-1:0]        tid_q;

  logic [IdW-1:0]        pick_grant, grant;
  logic                  pick_any, gnt_any;
  logic                  load, xfer, unit_end, turn_done;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_n_pick #(
    .N_INPUTS(N_INPUTS),
    .IdW     (IdW)
  ) u_pick (
    .valid(s_TVALID),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .any  (pick_any)
  );

  assign grant     = (state_q == StHold) ? lock_q : pick_grant;
  assign gnt_any   = (state_q == StHold) ? s_TVALID[lock_q] : pick_any;
  assign load      = !tvalid_q || o_TREADY;
  assign xfer      = gnt_any && load;
  assign unit_end  = (TLAST_ARB != 0) ? s_TLAST[grant] : 1'b1;
  assign turn_done = unit_end && (cnt_q == CntWidth'(QUANTUM - 1));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant == IdW'(i)) sel_data = s_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Gate with rst so no source sees a handshake while reset is held.
  always_comb begin
    s_TREADY = '0;
    if (rst && xfer) s_TREADY[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    mid_d   = mid_q;
    case (state_q)
      StArb: begin
        if (xfer) begin
          if (turn_done) begin
            ptr_d = grant;
            cnt_d = '0;
            mid_d = 1'b0;
          end else begin
            state_d = StHold;
            lock_d  = grant;
            mid_d   = !unit_end;
            if (unit_end) cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      StHold: begin
        if (xfer) begin
          if (turn_done) begin
            state_d = StArb;
            ptr_d   = lock_q;
            cnt_d   = '0;
            mid_d   = 1'b0;
          end else begin
            mid_d = !unit_end;
            if (unit_end) cnt_d = cnt_q + CntWidth'(1);
          end
        end else if (!mid_q && !s_TVALID[lock_q]) begin
          // Idle at a unit boundary: give up the rest of the quantum.
          state_d = StArb;
          ptr_d   = lock_q;
          cnt_d   = '0;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StArb;
      ptr_q   <= IdW'(N_INPUTS - 1);
      lock_q  <= '0;
      cnt_q   <= '0;
      mid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      mid_q   <= mid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
    end else if (load) begin
      tvalid_q <= xfer;
      if (xfer) begin
        tdata_q <= sel_data;
        tlast_q <= s_TLAST[grant];
        tid_q   <= grant;
      end
    end
  end

  assign o_TVALID = tvalid_q;
  assign o_TDATA  = tdata_q;
  assign o_TLAST  = tlast_q;
  assign o_TID    = tid_q;

`ifdef RR_N_STATS_EN
  logic [StatsWidth-1:0] pkt_cnt_q [N_INPUTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) pkt_cnt_q[i] <= '0;
    end else if (xfer && s_TLAST[grant]) begin
      pkt_cnt_q[grant] <= pkt_cnt_q[grant] + StatsWidth'(1);
    end
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_stats
    assign o_pkt_cnt[i*StatsWidth +: StatsWidth] = pkt_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_rr_n.sv
// Directed bench for rr_n: four instances with different arbitration settings share one stimulus.
module tb_rr_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [3:0]  s_valid, s_last;
  logic        o_rdy;

  logic [7:0]  a_tdata, b_tdata, c_tdata, d_tdata;
  logic        a_tvalid, b_tvalid, c_tvalid, d_tvalid;
  logic        a_tlast, b_tlast, c_tlast, d_tlast;
  logic [1:0]  a_tid, b_tid, c_tid, d_tid;
  logic [3:0]  a_tready, b_tready, c_tready, d_tready;
`ifdef RR_N_STATS_EN
  logic [63:0] a_cnt, b_cnt, c_cnt, d_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp039 [6] = '{0, 0, 3, 3, 0, 0};

  always #5 clk = ~clk;

  rr_n #(.N_INPUTS(4), .DATA_WIDTH(8), .TLAST_ARB(0), .QUANTUM(1)) dut_a (
    .clk(clk), .rst(rst), .s_TDATA(s_data), .s_TVALID(s_valid), .s_TREADY(a_tready),
    .s_TLAST(s_last), .o_TDATA(a_tdata), .o_TVALID(a_tvalid), .o_TREADY(o_rdy),
    .o_TLAST(a_tlast), .o_TID(a_tid)
`ifdef RR_N_STATS_EN
    , .o_pkt_cnt(a_cnt)
`endif
  );

  rr_n #(.N_INPUTS(4), .DATA_WIDTH(8), .TLAST_ARB(1), .QUANTUM(1)) dut_b (
    .clk(clk), .rst(rst), .s_TDATA(s_data), .s_TVALID(s_valid), .s_TREADY(b_tready),
    .s_TLAST(s_last), .o_TDATA(b_tdata), .o_TVALID(b_tvalid), .o_TREADY(o_rdy),
    .o_TLAST(b_tlast), .o_TID(b_tid)
`ifdef RR_N_STATS_EN
    , .o_pkt_cnt(b_cnt)
`endif
  );

  rr_n #(.N_INPUTS(4), .DATA_WIDTH(8), .TLAST_ARB(1), .QUANTUM(2)) dut_c (
    .clk(clk), .rst(rst), .s_TDATA(s_data), .s_TVALID(s_valid), .s_TREADY(c_tready),
    .s_TLAST(s_last), .o_TDATA(c_tdata), .o_TVALID(c_tvalid), .o_TREADY(o_rdy),
    .o_TLAST(c_tlast), .o_TID(c_tid)
`ifdef RR_N_STATS_EN
    , .o_pkt_cnt(c_cnt)
`endif
  );

  rr_n #(.N_INPUTS(4), .DATA_WIDTH(8), .TLAST_ARB(1), .QUANTUM(4)) dut_d (
    .clk(clk), .rst(rst), .s_TDATA(s_data), .s_TVALID(s_valid), .s_TREADY(d_tready),
    .s_TLAST(s_last), .o_TDATA(d_tdata), .o_TVALID(d_tvalid), .o_TREADY(o_rdy),
    .o_TLAST(d_tlast), .o_TID(d_tid)
`ifdef RR_N_STATS_EN
    , .o_pkt_cnt(d_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    o_rdy   = 1'b1;
    s_valid = 4'h0;
    s_last  = 4'h0;
    s_data  = 32'h1312_1110;
    repeat (2) @(negedge clk);

    // Reset values, and no ready while reset is held even with all inputs valid.
    s_valid = 4'hF;
    #1;
    chk("rst_tvalid", a_tvalid, 0);
    chk("rst_tdata", a_tdata, 0);
    chk("rst_tlast", a_tlast, 0);
    chk("rst_tid", a_tid, 0);
    chk("rst_tready_a", a_tready, 0);
    chk("rst_tready_b", b_tready, 0);

    // Flit-granular, quantum 1, everyone valid: 0,1,2,3,0.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr_first_ready", a_tready, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_tid", a_tid, i % 4);
      chk("rr_tdata", a_tdata, 8'h10 + 8'(i % 4));
      chk("rr_tvalid", a_tvalid, 1);
    end

    // Backpressure: output frozen for 5 cycles, then resumes at input 1 without loss.
    o_rdy = 1'b0;
    #1;
    chk("bp_ready0", a_tready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tid", a_tid, 0);
      chk("bp_tdata", a_tdata, 8'h10);
      chk("bp_tvalid", a_tvalid, 1);
      chk("bp_tready", a_tready, 0);
    end
    o_rdy = 1'b1;
    #1;
    chk("bp_resume_ready", a_tready, 4'b0010);
    @(negedge clk);
    chk("bp_next_tid", a_tid, 1);
    @(negedge clk);
    chk("bp_next2_tid", a_tid, 2);

    // Packet-granular: s1 3-flit packet with a mid-packet valid gap, then s2.
    s_valid = 4'b0010;
    s_last  = 4'b0000;
    s_data  = 32'h1312_A110;
    do_reset();
    @(negedge clk);
    chk("pkt_f1_tid", b_tid, 1);
    chk("pkt_f1_tdata", b_tdata, 8'hA1);
    chk("pkt_f1_tlast", b_tlast, 0);
    s_valid = 4'b0101;
    s_last  = 4'b0101;
    #1;
    chk("pkt_gap_ready", b_tready, 0);
    @(negedge clk);
    chk("pkt_gap_tvalid", b_tvalid, 0);
    s_valid = 4'b0111;
    s_data[15:8] = 8'hA2;
    #1;
    chk("pkt_f2_ready", b_tready, 4'b0010);
    @(negedge clk);
    chk("pkt_f2_tid", b_tid, 1);
    chk("pkt_f2_tdata", b_tdata, 8'hA2);
    s_data[15:8] = 8'hA3;
    s_last = 4'b0111;
    @(negedge clk);
    chk("pkt_f3_tid", b_tid, 1);
    chk("pkt_f3_tdata", b_tdata, 8'hA3);
    chk("pkt_f3_tlast", b_tlast, 1);
    @(negedge clk);
    chk("pkt_next_tid", b_tid, 2);
    chk("pkt_next_tdata", b_tdata, 8'h12);

    // Quantum 2, 1-flit packets on s0 and s3: 0,0,3,3,0,0.
    s_valid = 4'b1001;
    s_last  = 4'b1001;
    s_data  = 32'h1312_1110;
    do_reset();
    #1;
    chk("q2_first_ready", c_tready, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("q2_tid", c_tid, exp039[i]);
      chk("q2_tdata", c_tdata, (exp039[i] == 3) ? 8'h13 : 8'h10);
      chk("q2_tlast", c_tlast, 1);
      chk("q2_tvalid", c_tvalid, 1);
    end

    // Quantum 4: s2 sends one packet then goes idle, forfeits, s0 follows.
    s_valid = 4'b0100;
    s_last  = 4'b0100;
    do_reset();
    @(negedge clk);
    chk("ff_tid", d_tid, 2);
    chk("ff_tvalid", d_tvalid, 1);
    s_valid = 4'b0001;
    s_last  = 4'b0101;
    @(negedge clk);
    chk("ff_gap_tvalid", d_tvalid, 0);
    #1;
    chk("ff_ready", d_tready, 4'b0001);
    @(negedge clk);
    chk("ff_s0_tid", d_tid, 0);
    chk("ff_s0_tvalid", d_tvalid, 1);
    chk("ff_s0_tdata", d_tdata, 8'h10);
    chk("ff_s0_tlast", d_tlast, 1);

    // Reset mid-packet on s1: output drops at once, restart at s0.
    s_valid = 4'b0010;
    s_last  = 4'b0000;
    do_reset();
    @(negedge clk);
    chk("mr_pre_tid", b_tid, 1);
    chk("mr_pre_tvalid", b_tvalid, 1);
    rst = 1'b0;
    #1;
    chk("mr_tvalid", b_tvalid, 0);
    chk("mr_tid", b_tid, 0);
    chk("mr_tready", b_tready, 0);
`ifdef RR_N_STATS_EN
    chk("mr_pkt_cnt", b_cnt, 0);
`endif
    s_valid = 4'hF;
    s_last  = 4'hF;
    rst     = 1'b1;
    @(negedge clk);
    chk("mr_post_tid", b_tid, 0);
    chk("mr_post_tvalid", b_tvalid, 1);
`ifdef RR_N_STATS_EN
    chk("mr_post_pkt_cnt", b_cnt, 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
